hamming_serial_encoder: RTL and testbench
=========================================

HAMMING_SERIAL_ENCODER -- requirements
Module: hamming_serial_encoder

Interface
REQ-001 Parameter R, default 4: number of Hamming parity bits, legal range 3..6.
REQ-002 Parameter EXTENDED, default 0: 1 appends an overall-parity bit, giving SEC-DED.
REQ-003 Derived constant K = 2^R-1-R: data bits per block (11 at default).
REQ-004 Derived constant N = 2^R-1+EXTENDED: code bits per block (15 at default).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_bit carries a valid data bit this cycle.
REQ-008 in_bit  input  1  serial data bit.
REQ-009 in_ready  output  1  the block accepts in_bit this cycle.
REQ-010 out_valid  output  1  out_bit carries a valid code bit.
REQ-011 out_bit  output  1  serial code bit.
REQ-012 out_ready  input  1  the sink accepts out_bit this cycle.
REQ-013 out_first  output  1  out_bit is code position 1 of a block; qualified by out_valid.
REQ-014 out_last  output  1  out_bit is the final bit of a block; qualified by out_valid.

Function
REQ-015 An input bit is accepted on each cycle with in_valid=1 and in_ready=1; the first accepted bit is d0.
REQ-016 An output bit is consumed on each cycle with out_valid=1 and out_ready=1.
REQ-017 Input FSM states: COLLECT (in_ready=1; count 0..K-1) and FULL (in_ready=0; K bits held).
REQ-018 In COLLECT, the K-th accepted bit moves the input FSM to FULL, unless a same-cycle load occurs (REQ-020).
REQ-019 Output FSM states: IDLE (out_valid=0) and SEND (out_valid=1; index 0..N-1).
REQ-020 Load condition: input has K bits and output is IDLE or consuming its final bit this cycle.
REQ-021 On load, the encoded word enters the output shift register, index resets to 0, output enters SEND, and input returns to COLLECT with count 0.
REQ-022 A load on the same cycle as the K-th input acceptance is permitted, giving zero bubble between blocks.
REQ-023 Back-to-back blocks at full rate with out_ready held at 1 produce no idle output cycle.
REQ-024 Latency: the first out_bit is valid the cycle after the K-th input acceptance, provided the output is free.
REQ-025 Data bits occupy non-power-of-two code positions 3,5,6,7,9,... in ascending order d0, d1, and so on.
REQ-026 Parity bit p(2^i) sits at position 2^i and is the even parity of all positions whose index has bit i set.
REQ-027 When EXTENDED=1, position N is the XOR of positions 1..N-1, so whole-word parity is even.
REQ-028 Transmission order is position 1 first, ascending; out_first is asserted at index 0 and out_last at index N-1.
REQ-029 When out_ready=0, out_bit, out_first and out_last are held stable.
REQ-030 When in_valid=0 the input count holds, with no timeout.

Reset
REQ-031 While reset=0: in_ready=0, out_valid=0, out_bit=0, out_first=0, out_last=0; the input FSM is in COLLECT with count 0; the output FSM is IDLE; all registers are cleared.
REQ-032 Reset asserted mid-block discards partial input and any untransmitted output.
REQ-033 in_ready rises in the first clock cycle after reset deasserts.

Structure
REQ-034 Shared package hamming_pkg holds the K and N calculation functions, the power-of-two test function, and the FSM state typedefs.
REQ-035 Encoding is a purely combinational sub-module, hamming_encode_comb, parametrised by R and EXTENDED: K bits in, N bits out.
REQ-036 No derived or divided clocks are used; rate control is by handshake only.

Verification
REQ-037 Defaults; input d=11'h000 -> output 15 bits all 0; out_first on bit 1, out_last on bit 15.
REQ-038 Defaults; d0=1 and all other bits 0 -> output positions 1,2,3 = 1 and the rest 0; with EXTENDED=1, the 16th bit = 1.
REQ-039 Defaults; input 11'h7FF -> output 15 ones.
REQ-040 Two blocks streamed with in_valid=1 and out_ready=1 -> 30 consecutive out_valid cycles; in_ready low for 0 cycles after the first block.
REQ-041 out_ready=0 for 20 cycles mid-block -> out_bit held; in_ready drops after 11 more accepted bits; no bit lost.
REQ-042 reset pulsed after 5 input bits -> outputs zero; the next 11 bits encode as a fresh block; R=3 and R=5 are regressed against a reference model.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared sizing helpers and FSM state types
// for the serial Hamming encoder.
package hamming_pkg;

  typedef logic in_state_t;
  typedef logic out_state_t;

  localparam in_state_t  ST_COLLECT = 1'b0;
  localparam in_state_t  ST_FULL    = 1'b1;
  localparam out_state_t ST_IDLE    = 1'b0;
  localparam out_state_t ST_SEND    = 1'b1;

  function automatic int calc_k(input int r);
    return (1 << r) - 1 - r;
  endfunction

  function automatic int calc_n(input int r, input int ext);
    return (1 << r) - 1 + ext;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bit index carried at code position p (p not a power of two).
  function automatic int data_index(input int p);
    int cnt;
    cnt = 0;
    for (int q = 1; q < p; q++)
      if (!is_pow2(q)) cnt++;
    return cnt;
  endfunction

  function automatic logic [63:0] par_mask(input int i);
    logic [63:0] m;
    m = '0;
    for (int p = 1; p < 64; p++)
      if (((p >> i) & 1) != 0) m = m | (64'd1 << (p - 1));
    return m;
  endfunction

endpackage

// File: rtl/hamming_encode_comb.sv
// Combinational Hamming encoder; code[0] is
// code position 1.
module hamming_encode_comb
  import hamming_pkg::*;
#(
  parameter int R        = 4,
  parameter int EXTENDED = 0,
  localparam int K = calc_k(R),
  localparam int N = calc_n(R, EXTENDED)
) (
  input  logic [K-1:0] data,
  output logic [N-1:0] code
);

  localparam int M = (1 << R) - 1;

  logic [M-1:0] raw;
  logic [M-1:0] ham;
  logic [R-1:0] par;

  for (genvar p = 1; p <= M; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign raw[p-1] = 1'b0;
      assign ham[p-1] = par[$clog2(p)];
    end else begin : g_dat
      assign raw[p-1] = data[data_index(p)];
      assign ham[p-1] = raw[p-1];
    end
  end

  for (genvar i = 0; i < R; i++) begin : g_chk
    localparam logic [63:0] MASK = par_mask(i);
    assign par[i] = ^(raw & MASK[M-1:0]);
  end

  if (EXTENDED != 0) begin : g_ext
    assign code = {^ham, ham};
  end else begin : g_std
    assign code = ham;
  end

endmodule

// File: rtl/hamming_serial_encoder.sv
// Serial-in / serial-out Hamming encoder with
// valid/ready on both sides and zero-bubble reload.
module hamming_serial_encoder
  import hamming_pkg::*;
#(
  parameter int R        = 4,
  parameter int EXTENDED = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  input  logic out_ready,
  output logic out_first,
  output logic out_last
);

  localparam int K  = calc_k(R);
  localparam int N  = calc_n(R, EXTENDED);
  localparam int CW = $clog2(K);
  localparam int IW = $clog2(N);

  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  in_state_t     in_state;
  out_state_t    out_state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [K-1:0]  dat;
  logic [K-1:0]  word;
  logic [N-1:0]  code;
  logic [N-1:0]  sreg;
  logic          alive;
  logic          in_acc;
  logic          out_acc;
  logic          in_done;
  logic          out_free;
  logic          load;

  assign in_ready  = alive & (in_state == ST_COLLECT);
  assign in_acc    = in_valid & in_ready;
  assign out_valid = (out_state == ST_SEND);
  assign out_acc   = out_valid & out_ready;

  // A block is complete either already held or on its K-th bit now.
  assign in_done  = (in_state == ST_FULL)
                  | (in_acc & (cnt == CNT_LAST));
  assign out_free = ~out_valid
                  | (out_acc & (idx == IDX_LAST));
  assign load     = in_done & out_free;

  always_comb begin
    word = dat;
    if (in_acc) word[cnt] = in_bit;
  end

  hamming_encode_comb #(
    .R        (R),
    .EXTENDED (EXTENDED)
  ) u_enc (
    .data (word),
    .code (code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state <= ST_COLLECT;
      cnt      <= '0;
      dat      <= '0;
    end else begin
      if (in_acc) dat[cnt] <= in_bit;
      if (load) begin
        in_state <= ST_COLLECT;
        cnt      <= '0;
      end else if (in_acc) begin
        if (cnt == CNT_LAST) in_state <= ST_FULL;
        else                 cnt      <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= ST_IDLE;
      idx       <= '0;
      sreg      <= '0;
    end else if (load) begin
      out_state <= ST_SEND;
      idx       <= '0;
      sreg      <= code;
    end else if (out_acc) begin
      if (idx == IDX_LAST) begin
        out_state <= ST_IDLE;
      end else begin
        idx  <= idx + 1'b1;
        sreg <= sreg >> 1;
      end
    end
  end

  assign out_bit   = out_valid & sreg[0];
  assign out_first = out_valid & (idx == '0);
  assign out_last  = out_valid & (idx == IDX_LAST);

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Bench for hamming_serial_encoder: four parameter sets
// share one stimulus stream, each scored by a reference model.
module tb_hamming_serial_encoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic [3:0] in_ready_v;
  logic [3:0] out_valid_v;
  logic [3:0] out_bit_v;
  logic [3:0] out_first_v;
  logic [3:0] out_last_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int GR = (g == 2) ? 3 : (g == 3) ? 5 : 4;
    localparam int GE = (g == 1) ? 1 : 0;
    hamming_serial_encoder #(
      .R        (GR),
      .EXTENDED (GE)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready_v[g]),
      .out_valid (out_valid_v[g]),
      .out_bit   (out_bit_v[g]),
      .out_ready (out_ready),
      .out_first (out_first_v[g]),
      .out_last  (out_last_v[g])
    );
  end

  always #5 clk = ~clk;

  int          RR[4] = '{4, 4, 3, 5};
  int          EE[4] = '{0, 1, 0, 0};
  int          KK[4];
  int          NN[4];
  bit          dbuf[4][64];
  int          cnt[4];
  bit          exp_b[4][4096];
  int          wr[4];
  int          rd[4];
  int          pos[4];
  bit          due[4];
  int          nout[4];
  logic [63:0] cap[4];
  int          checks;
  int          failures;
  int          run0;
  int          maxrun0;
  int          nvalid0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic encode_push(input int g);
    int m;
    int j;
    int s;
    bit c[66];
    m = (1 << RR[g]) - 1;
    j = 0;
    for (int p = 1; p <= m; p++) begin
      if ((p & (p - 1)) == 0) c[p] = 1'b0;
      else begin
        c[p] = dbuf[g][j];
        j++;
      end
    end
    for (int i = 0; i < RR[g]; i++) begin
      s = 0;
      for (int p = 1; p <= m; p++)
        if (((p >> i) % 2) == 1) s += int'(c[p]);
      c[1 << i] = (s % 2) == 1;
    end
    if (EE[g] != 0) begin
      s = 0;
      for (int p = 1; p <= m; p++) s += int'(c[p]);
      c[m + 1] = (s % 2) == 1;
    end
    for (int p = 1; p <= NN[g]; p++) begin
      exp_b[g][wr[g] % 4096] = c[p];
      wr[g]++;
    end
  endtask

  task automatic observe();
    bit free;
    if (reset) begin
      for (int g = 0; g < 4; g++) begin
        if (due[g]) begin
          chk($sformatf("latency[%0d]", g),
              {62'd0, out_valid_v[g], out_first_v[g]}, 64'd3);
          due[g] = 1'b0;
        end
        free = !out_valid_v[g] || (out_ready && pos[g] == NN[g] - 1);
        if (out_valid_v[g] && out_ready) begin
          chk($sformatf("sb_nonempty[%0d]", g), 64'(wr[g] > rd[g]), 64'd1);
          if (wr[g] > rd[g]) begin
            chk($sformatf("out_bit[%0d]", g), 64'(out_bit_v[g]),
                64'(exp_b[g][rd[g] % 4096]));
            rd[g]++;
          end
          chk($sformatf("out_first[%0d]", g), 64'(out_first_v[g]),
              64'(pos[g] == 0));
          chk($sformatf("out_last[%0d]", g), 64'(out_last_v[g]),
              64'(pos[g] == NN[g] - 1));
          cap[g][pos[g]] = out_bit_v[g];
          nout[g]++;
          pos[g] = (pos[g] == NN[g] - 1) ? 0 : pos[g] + 1;
        end
        if (in_valid && in_ready_v[g]) begin
          dbuf[g][cnt[g]] = in_bit;
          cnt[g]++;
          if (cnt[g] == KK[g]) begin
            encode_push(g);
            cnt[g] = 0;
            due[g] = free;
          end
        end
      end
      if (out_valid_v[0]) begin
        run0++;
        nvalid0++;
      end else begin
        if (run0 > maxrun0) maxrun0 = run0;
        run0 = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    #1;
    chk("reset_outputs",
        64'({in_ready_v, out_valid_v, out_bit_v, out_first_v, out_last_v}),
        64'd0);
    for (int g = 0; g < 4; g++) begin
      cnt[g]  = 0;
      rd[g]   = wr[g];
      pos[g]  = 0;
      due[g]  = 1'b0;
      nout[g] = 0;
      cap[g]  = '0;
    end
    repeat (2) cycle();
    reset = 1'b1;
    chk("ready_before_edge", 64'(in_ready_v), 64'd0);
    cycle();
    chk("ready_after_reset", 64'(in_ready_v), 64'hF);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = v[i];
      cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (out_valid_v != 4'd0 && t < 300) begin
      cycle();
      t++;
    end
    chk("drain_bound", 64'(t < 300), 64'd1);
    cycle();
  endtask

  int   stall0;
  int   acc;
  int   changes;
  logic held_bit;
  logic held_first;
  logic held_last;

  initial begin
    clk       = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    checks    = 0;
    failures  = 0;
    run0      = 0;
    maxrun0   = 0;
    nvalid0   = 0;
    for (int g = 0; g < 4; g++) begin
      KK[g] = (1 << RR[g]) - 1 - RR[g];
      NN[g] = (1 << RR[g]) - 1 + EE[g];
      wr[g] = 0;
      rd[g] = 0;
    end
    @(posedge clk);
    #1;

    do_reset();
    send_bits(64'h0, 11);
    drain();
    chk("zeros_r4", 64'(cap[0][14:0]), 64'h0);
    chk("zeros_r4x", 64'(cap[1][15:0]), 64'h0);

    do_reset();
    send_bits(64'h1, 11);
    drain();
    chk("d0_r4", 64'(cap[0][14:0]), 64'h0007);
    chk("d0_r4x", 64'(cap[1][15:0]), 64'h8007);

    do_reset();
    send_bits(64'h7FF, 11);
    drain();
    chk("ones_r4", 64'(cap[0][14:0]), 64'h7FFF);
    chk("ones_r4x", 64'(cap[1][15:0]), 64'hFFFF);

    do_reset();
    run0    = 0;
    maxrun0 = 0;
    nvalid0 = 0;
    stall0  = 0;
    for (int i = 0; i < 22; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      if (!in_ready_v[0]) stall0++;
      cycle();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_in_stall", 64'(stall0), 64'd0);
    chk("b2b_run", 64'(maxrun0), 64'd30);
    chk("b2b_valid", 64'(nvalid0), 64'd30);

    do_reset();
    send_bits(64'($urandom), 11);
    repeat (3) cycle();
    held_bit   = out_bit_v[0];
    held_first = out_first_v[0];
    held_last  = out_last_v[0];
    out_ready  = 1'b0;
    acc        = 0;
    changes    = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      if (in_ready_v[0]) acc++;
      cycle();
      if (out_bit_v[0] !== held_bit || out_first_v[0] !== held_first ||
          out_last_v[0] !== held_last || out_valid_v[0] !== 1'b1)
        changes++;
    end
    chk("stall_accepts", 64'(acc), 64'd11);
    chk("stall_hold", 64'(changes), 64'd0);
    chk("stall_ready_low", 64'(in_ready_v[0]), 64'd0);
    drain();
    chk("stall_no_loss", 64'(nout[0]), 64'd30);

    do_reset();
    send_bits(64'($urandom), 16);
    chk("mid_block_busy", 64'(out_valid_v[0]), 64'd1);
    do_reset();
    send_bits(64'h1, 11);
    drain();
    chk("fresh_block", 64'(cap[0][14:0]), 64'h0007);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 10) < 7;
      in_bit    = 1'($urandom);
      out_ready = ($urandom % 10) < 7;
      cycle();
    end
    drain();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sb_empty[%0d]", g), 64'(rd[g] == wr[g]), 64'd1);
      chk($sformatf("rand_traffic[%0d]", g), 64'(nout[g] > 100), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
